count_expander: RTL and testbench

//   Inverse of the popcount compressor tree: turns ones-counts back into bit frames.

---
 rtl/count_expander.sv | 120 ++++++++++++
 tb/tb_count_expander.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_expander.sv
// rtl/count_expander.sv - ones-count to thermometer bit-frame serializer with count FIFO (optional COUNT_EXPANDER_ERR_EN adds sticky err)
module count_expander #(
    parameter int FRAME_BITS = 7,
    parameter int CNT_W      = 3,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
`ifdef COUNT_EXPANDER_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] FB_CNT   = CNT_W'(FRAME_BITS);
    localparam logic [IW-1:0]    FB_IDX   = IW'(FRAME_BITS);
    localparam logic [IW-1:0]    LAST_IDX = IW'(FRAME_BITS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] head;
    logic [IW-1:0]    head_ones;

    logic [0:0]       state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    ones;
    logic             at_last;

    // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;

    // Saturate oversized counts so the frame is simply all ones.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_ones = (head > FB_CNT) ? FB_IDX : IW'(head);

    // Pop when idle, or on the last accepted bit so back-to-back frames have no bubble.
    assign at_last = (state == S_EMIT) && (idx == LAST_IDX);
    assign pop     = !fifo_empty && ((state == S_IDLE) || (out_ready && at_last));

    // All outputs derive from registered state only, so a stall cannot glitch them.
    assign out_valid = (state == S_EMIT);
    assign out_bit   = out_valid && (idx < ones);
    assign out_last  = at_last;
    assign busy      = out_valid || !fifo_empty;

    // Count storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_count;
        end
    end

    // FIFO pointers; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Serializer: load a frame on pop, advance one bit per output handshake.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
            idx   <= '0;
            ones  <= '0;
        end else if (pop) begin
            state <= S_EMIT;
            idx   <= '0;
            ones  <= head_ones;
        end else if ((state == S_EMIT) && out_ready) begin
            if (at_last) begin
                state <= S_IDLE;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

`ifdef COUNT_EXPANDER_ERR_EN
    // Sticky flag for any accepted count that had to be saturated.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            err <= 1'b0;
        end else if (push && (in_count > FB_CNT)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_count_expander.sv
// tb/tb_count_expander.sv - randomized and directed bench for count_expander against a frame-queue model
module tb_count_expander;

    localparam int FB = 7;
    localparam int CW = 4;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_bit;
    logic          out_last;
    logic          busy;
`ifdef COUNT_EXPANDER_ERR_EN
    logic          err;
    logic          err_exp = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int run;
    logic [1:0] exp_q[$];

    count_expander #(.FRAME_BITS(FB), .CNT_W(CW), .DEPTH(DP)) dut (
        .clk(clk),
        .nReset(nReset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_count(in_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit(out_bit),
        .out_last(out_last),
        .busy(busy)
`ifdef COUNT_EXPANDER_ERR_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Model: every accepted count becomes FB expected {bit,last} pairs, consumed per output handshake.
    always @(negedge clk) begin
        if (!nReset) begin
            exp_q.delete();
`ifdef COUNT_EXPANDER_ERR_EN
            err_exp = 1'b0;
`endif
        end else begin
            chk("busy", busy, exp_q.size() != 0);
            if (out_valid) begin
                chk("valid_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("out_bit", out_bit, exp_q[0][1]);
                    chk("out_last", out_last, exp_q[0][0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
`ifdef COUNT_EXPANDER_ERR_EN
            chk("err", err, err_exp);
`endif
            if (in_valid && in_ready) begin
                int n;
                n = (int'(in_count) > FB) ? FB : int'(in_count);
                for (int i = 0; i < FB; i++) exp_q.push_back({logic'(i < n), logic'(i == FB - 1)});
`ifdef COUNT_EXPANDER_ERR_EN
                if (int'(in_count) > FB) err_exp = 1'b1;
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c);
        logic ok;
        ok = 1'b0;
        in_count = CW'(c);
        in_valid = 1'b1;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        cyc();
        in_valid = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic drain();
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("drain", (exp_q.size() == 0) && !busy, 1);
        cyc();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_bit"}, out_bit, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        // reset state
        repeat (3) cyc();
        chk_reset_outputs("reset");
        nReset = 1'b1;
        cyc();
        chk("post_reset_ready", in_ready, 1);

        // single frame and load latency
        out_ready = 1'b1;
        push(3);
        @(negedge clk);
        chk("latency_e0", out_valid, 0);
        @(negedge clk);
        chk("latency_e1", out_valid, 1);
        cyc();
        drain();
        chk("idle_after_frame", out_valid, 0);

        // back-to-back frames without a bubble
        push(0);
        push(7);
        run = 0;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (out_valid) run++;
            else if (run > 0) break;
        end
        chk("no_bubble_run", run, 2 * FB);
        cyc();
        drain();

        // fill while stalled: DEPTH in FIFO plus one in the serializer
        out_ready = 1'b0;
        push(2); push(4); push(6); push(1); push(5);
        in_count = CW'(3);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_blocks", in_ready, 0);
            chk("stall_bit", out_bit, 1);
        end
        cyc();
        out_ready = 1'b1;
        push(3);
        drain();

        // saturation of oversized counts
        push(9);
        push(2);
        push(15);
        push(7);
        drain();
`ifdef COUNT_EXPANDER_ERR_EN
        chk("err_sticky", err, 1);
`endif

        // reset mid-frame with FIFO contents
        push(5);
        push(6);
        push(4);
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        repeat (3) @(posedge clk);
        #1;
        nReset = 1'b0;
        #1;
        chk_reset_outputs("midrun");
        cyc();
        cyc();
        chk_reset_outputs("hold");
`ifdef COUNT_EXPANDER_ERR_EN
        chk("err_cleared", err, 0);
`endif
        nReset = 1'b1;
        cyc();
        chk("release_busy", busy, 0);
        chk("release_valid", out_valid, 0);
        push(2);
        drain();

        // randomized traffic with random back-pressure
        for (int k = 0; k < 800; k++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_count  = CW'($urandom_range(0, 15));
            out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
